// File: rtl/axi_slice_pkg.sv
// Shared types and limits for the AXI channel pipeline-cut chain.
package axi_slice_pkg;

  typedef enum logic {
    SLICE_FULL,
    SLICE_HALF
  } slice_mode_e;

  localparam int unsigned MAX_SLICE_DEPTH = 8;

endpackage

// File: rtl/axi_chan_cut_stage.sv
// One valid/ready register stage: 2-entry spill (FULL) or 1-entry (HALF).
// Outputs depend only on registers, so stages cascade without combinational paths.
module axi_chan_cut_stage
  import axi_slice_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter slice_mode_e MODE  = SLICE_FULL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  if (MODE == SLICE_FULL) begin : gen_full
    logic             a_valid_q, a_valid_d, b_valid_q, b_valid_d;
    logic [WIDTH-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
    logic             in_xfer, out_xfer;

    assign in_xfer  = valid_i & ~b_valid_q;
    assign out_xfer = a_valid_q & ready_i;

    always_comb begin
      a_valid_d = a_valid_q;
      a_data_d  = a_data_q;
      b_valid_d = b_valid_q;
      b_data_d  = b_data_q;
      if (out_xfer) begin
        a_valid_d = b_valid_q;
        b_valid_d = 1'b0;
        if (b_valid_q) a_data_d = b_data_q;
      end
      // The skid slot is only used when the output slot stays occupied.
      if (in_xfer) begin
        if (!a_valid_d) begin
          a_valid_d = 1'b1;
          a_data_d  = data_i;
        end else begin
          b_valid_d = 1'b1;
          b_data_d  = data_i;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        a_valid_q <= 1'b0;
        b_valid_q <= 1'b0;
        a_data_q  <= '0;
        b_data_q  <= '0;
      end else begin
        a_valid_q <= a_valid_d;
        b_valid_q <= b_valid_d;
        a_data_q  <= a_data_d;
        b_data_q  <= b_data_d;
      end
    end

    assign ready_o = ~b_valid_q;
    assign valid_o = a_valid_q;
    assign data_o  = a_data_q;
    assign count_o = {a_valid_q & b_valid_q, a_valid_q ^ b_valid_q};

  end else begin : gen_half
    logic             slot_valid_q, slot_valid_d;
    logic [WIDTH-1:0] slot_data_q, slot_data_d;

    // Never accepts while holding a beat, so a drain and a fill cannot overlap.
    always_comb begin
      slot_valid_d = slot_valid_q;
      slot_data_d  = slot_data_q;
      if (slot_valid_q && ready_i) begin
        slot_valid_d = 1'b0;
      end else if (!slot_valid_q && valid_i) begin
        slot_valid_d = 1'b1;
        slot_data_d  = data_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        slot_valid_q <= 1'b0;
        slot_data_q  <= '0;
      end else begin
        slot_valid_q <= slot_valid_d;
        slot_data_q  <= slot_data_d;
      end
    end

    assign ready_o = ~slot_valid_q;
    assign valid_o = slot_valid_q;
    assign data_o  = slot_data_q;
    assign count_o = {1'b0, slot_valid_q};
  end

endmodule

// File: rtl/axi_chan_multicut_ctrl.sv
// Chain of DEPTH cut stages for one AXI channel, with occupancy reporting
// and a saturating stall counter (cycles with valid_o && !ready_i).
module axi_chan_multicut_ctrl
  import axi_slice_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 2,
  parameter slice_mode_e MODE      = SLICE_FULL,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [WIDTH-1:0]              data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [WIDTH-1:0]              data_o,
  output logic                          idle_o,
  output logic [$clog2(2*DEPTH+2)-1:0]  occupancy_o,
  output logic [CNT_WIDTH-1:0]          stall_cnt_o,
  input  logic                          stall_clr_i
);

  localparam int unsigned OccW = $clog2(2*DEPTH+2);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  if (DEPTH > MAX_SLICE_DEPTH) begin : gen_depth_check
    $error("axi_chan_multicut_ctrl: DEPTH exceeds MAX_SLICE_DEPTH");
  end

  if (DEPTH == 0) begin : gen_bypass
    assign ready_o     = ready_i;
    assign valid_o     = valid_i;
    assign data_o      = data_i;
    assign occupancy_o = '0;
  end else begin : gen_chain
    logic [DEPTH:0]   vld, rdy;
    logic [WIDTH-1:0] dat [DEPTH+1];
    logic [1:0]       cnt [DEPTH];
    logic [OccW-1:0]  occ;

    assign vld[0]     = valid_i;
    assign dat[0]     = data_i;
    assign ready_o    = rdy[0];
    assign valid_o    = vld[DEPTH];
    assign data_o     = dat[DEPTH];
    assign rdy[DEPTH] = ready_i;

    for (genvar k = 0; k < DEPTH; k++) begin : gen_stage
      axi_chan_cut_stage #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
      ) u_stage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (vld[k]),
        .ready_o (rdy[k]),
        .data_i  (dat[k]),
        .valid_o (vld[k+1]),
        .ready_i (rdy[k+1]),
        .data_o  (dat[k+1]),
        .count_o (cnt[k])
      );
    end

    // Sum of stage slot flags; depends only on stage registers.
    always_comb begin
      occ = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        occ = occ + OccW'(cnt[k]);
      end
    end

    assign occupancy_o = occ;
  end

  assign idle_o = (occupancy_o == '0);

  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr_i) begin
      stall_cnt_d = '0;
    end else if (valid_o && !ready_i && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_axi_chan_multicut_ctrl.sv
// Bench for axi_chan_multicut_ctrl: FULL/2, HALF/3 (2-bit counter) and bypass instances,
// a scoreboard monitor for beat order/content and directed per-cycle checks.
module tb_axi_chan_multicut_ctrl;
  import axi_slice_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        f_vi, f_ro, f_vo, f_ri, f_idle, f_clr;
  logic [15:0] f_di, f_do, f_stall;
  logic [2:0]  f_occ;

  logic        h_vi, h_ro, h_vo, h_ri, h_idle, h_clr;
  logic [15:0] h_di, h_do;
  logic [1:0]  h_stall;
  logic [2:0]  h_occ;

  logic        b_vi, b_ro, b_vo, b_ri, b_idle, b_clr;
  logic [15:0] b_di, b_do;
  logic [3:0]  b_stall;
  logic [0:0]  b_occ;

  axi_chan_multicut_ctrl #(.WIDTH(16), .DEPTH(2), .MODE(SLICE_FULL), .CNT_WIDTH(16)) u_full (
    .clk_i(clk), .rst_i(rst), .valid_i(f_vi), .ready_o(f_ro), .data_i(f_di),
    .valid_o(f_vo), .ready_i(f_ri), .data_o(f_do), .idle_o(f_idle),
    .occupancy_o(f_occ), .stall_cnt_o(f_stall), .stall_clr_i(f_clr)
  );

  axi_chan_multicut_ctrl #(.WIDTH(16), .DEPTH(3), .MODE(SLICE_HALF), .CNT_WIDTH(2)) u_half (
    .clk_i(clk), .rst_i(rst), .valid_i(h_vi), .ready_o(h_ro), .data_i(h_di),
    .valid_o(h_vo), .ready_i(h_ri), .data_o(h_do), .idle_o(h_idle),
    .occupancy_o(h_occ), .stall_cnt_o(h_stall), .stall_clr_i(h_clr)
  );

  axi_chan_multicut_ctrl #(.WIDTH(16), .DEPTH(0), .MODE(SLICE_FULL), .CNT_WIDTH(4)) u_byp (
    .clk_i(clk), .rst_i(rst), .valid_i(b_vi), .ready_o(b_ro), .data_i(b_di),
    .valid_o(b_vo), .ready_i(b_ri), .data_o(b_do), .idle_o(b_idle),
    .occupancy_o(b_occ), .stall_cnt_o(b_stall), .stall_clr_i(b_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] f_q[$], h_q[$], b_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted beats are queued, every downstream transfer pops and compares.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      f_q.delete();
      h_q.delete();
      b_q.delete();
    end else begin
      if (f_vi && f_ro) f_q.push_back(f_di);
      if (h_vi && h_ro) h_q.push_back(h_di);
      if (b_vi && b_ro) b_q.push_back(b_di);
      if (f_vo && f_ri) begin
        if (f_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL full_out: got beat 0x%0h, expected no beat", f_do);
        end else chk("full_out", 32'(f_do), 32'(f_q.pop_front()));
      end
      if (h_vo && h_ri) begin
        if (h_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL half_out: got beat 0x%0h, expected no beat", h_do);
        end else chk("half_out", 32'(h_do), 32'(h_q.pop_front()));
      end
      if (b_vo && b_ri) begin
        if (b_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL byp_out: got beat 0x%0h, expected no beat", b_do);
        end else chk("byp_out", 32'(b_do), 32'(b_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, k, maxocc;
    int occ_tab [9];
    occ_tab = '{0, 1, 1, 2, 2, 3, 3, 3, 3};
    rst = 1'b1;
    f_vi = 1'b0; f_ri = 1'b1; f_di = '0; f_clr = 1'b0;
    h_vi = 1'b0; h_ri = 1'b1; h_di = '0; h_clr = 1'b0;
    b_vi = 1'b0; b_ri = 1'b1; b_di = '0; b_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_f_valid", 32'(f_vo), 0);
    chk("rst_f_ready", 32'(f_ro), 1);
    chk("rst_f_data", 32'(f_do), 0);
    chk("rst_f_idle", 32'(f_idle), 1);
    chk("rst_f_occ", 32'(f_occ), 0);
    chk("rst_f_stall", 32'(f_stall), 0);
    chk("rst_h_ready", 32'(h_ro), 1);
    chk("rst_h_data", 32'(h_do), 0);

    // FULL streaming at full rate, latency of two cycles.
    for (int i = 0; i < 12; i++) begin
      tick();
      f_vi = (i < 8); f_di = 16'(i); f_ri = 1'b1;
      @(negedge clk);
      chk("t1_ready", 32'(f_ro), 1);
      chk("t1_valid", 32'(f_vo), 32'(i >= 2 && i < 10));
      if (i >= 2 && i < 10) chk("t1_data", 32'(f_do), 32'(i - 2));
    end

    // FULL back-pressure: four beats fill both stages.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      f_vi = 1'b1; f_di = 16'(16 + acc); f_ri = 1'b0;
      @(negedge clk);
      chk("t2_ready", 32'(f_ro), 32'(i < 4));
      chk("t2_occ", 32'(f_occ), 32'(i < 4 ? i : 4));
      chk("t2_valid", 32'(f_vo), 32'(i >= 2));
      chk("t2_stall", 32'(f_stall), 32'(i >= 2 ? i - 2 : 0));
      chk("t2_idle", 32'(f_idle), 32'(i == 0));
      if (f_vi && f_ro) acc++;
    end
    chk("t2_accepted", 32'(acc), 4);

    // Drain: the free slot ripples back one stage per cycle.
    for (int j = 0; j < 6; j++) begin
      tick();
      f_vi = 1'b0; f_ri = 1'b1;
      @(negedge clk);
      chk("t2_drain_ready", 32'(f_ro), 32'(j >= 2));
      chk("t2_drain_occ", 32'(f_occ), 32'(j < 4 ? 4 - j : 0));
      chk("t2_drain_valid", 32'(f_vo), 32'(j < 4));
      chk("t2_drain_stall", 32'(f_stall), 6);
    end
    tick();
    f_clr = 1'b1;
    tick();
    f_clr = 1'b0;
    @(negedge clk);
    chk("t2_clr", 32'(f_stall), 0);

    // HALF streaming: one beat per two cycles.
    k = 0; maxocc = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      h_vi = (k < 10); h_di = 16'(32 + k); h_ri = 1'b1;
      @(negedge clk);
      chk("t3_ready", 32'(h_ro), 32'(i >= 20 || (i % 2) == 0));
      if (int'(h_occ) > maxocc) maxocc = int'(h_occ);
      if (h_vi && h_ro) k++;
    end
    chk("t3_beats_in", 32'(k), 10);
    chk("t3_max_occ", 32'(maxocc), 2);
    chk("t3_all_out", 32'(h_q.size()), 0);

    // HALF fill under back-pressure, 2-bit stall counter saturates.
    k = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      h_vi = 1'b1; h_di = 16'(48 + k); h_ri = 1'b0;
      @(negedge clk);
      chk("t4_ready", 32'(h_ro), 32'(i < 5 && (i % 2) == 0));
      chk("t4_occ", 32'(h_occ), 32'(occ_tab[i]));
      chk("t4_valid", 32'(h_vo), 32'(i >= 3));
      chk("t4_stall", 32'(h_stall), 32'(i <= 3 ? 0 : (i - 3 > 3 ? 3 : i - 3)));
      if (h_vi && h_ro) k++;
    end
    chk("t4_accepted", 32'(k), 3);
    tick();
    h_clr = 1'b1;
    @(negedge clk);
    chk("t5_pre_clr", 32'(h_stall), 3);
    tick();
    h_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr", 32'(h_stall), 0);
    chk("t5_occ", 32'(h_occ), 3);
    tick();
    @(negedge clk);
    chk("t5_recount", 32'(h_stall), 1);

    // Reset with three beats held; none may emerge afterwards.
    tick();
    rst = 1'b1; h_di = 16'hdead;
    tick();
    rst = 1'b0; h_vi = 1'b0; h_ri = 1'b1;
    @(negedge clk);
    chk("t6_valid", 32'(h_vo), 0);
    chk("t6_data", 32'(h_do), 0);
    chk("t6_occ", 32'(h_occ), 0);
    chk("t6_idle", 32'(h_idle), 1);
    chk("t6_stall", 32'(h_stall), 0);
    chk("t6_ready", 32'(h_ro), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      chk("t6_no_beat", 32'(h_vo), 0);
    end

    // Bypass: outputs follow inputs within the cycle.
    for (int i = 0; i < 20; i++) begin
      tick();
      b_vi = 1'($urandom_range(0, 1));
      b_ri = 1'($urandom_range(0, 1));
      b_di = 16'($urandom);
      @(negedge clk);
      chk("t7_ready", 32'(b_ro), 32'(b_ri));
      chk("t7_valid", 32'(b_vo), 32'(b_vi));
      chk("t7_data", 32'(b_do), 32'(b_di));
      chk("t7_idle", 32'(b_idle), 1);
      chk("t7_occ", 32'(b_occ), 0);
    end
    chk("end_full_q", 32'(f_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
